// File: rtl/cpu_step_sequencer_if.sv
// cpu_step_sequencer_if: start/stall/instruction inputs and step status outputs of the step sequencer.
// The illegal_clr signal exists only when ILLEGAL_TRAP_EN is defined.
interface cpu_step_sequencer_if #(
  parameter int IW  = 12,
  parameter int OPW = 4,
  parameter int SW  = 4
);
  logic           w;
  logic           hold;
  logic [IW-1:0]  instruction;
  logic [SW-1:0]  step;
  logic [OPW-1:0] opcode_q;
  logic           busy;
  logic           done;
  logic           illegal;
`ifdef ILLEGAL_TRAP_EN
  logic           illegal_clr;
`endif
  modport master (
`ifdef ILLEGAL_TRAP_EN
    output illegal_clr,
`endif
    output w, hold, instruction,
    input  step, opcode_q, busy, done, illegal
  );
  modport slave (
`ifdef ILLEGAL_TRAP_EN
    input  illegal_clr,
`endif
    input  w, hold, instruction,
    output step, opcode_q, busy, done, illegal
  );
endinterface

// File: rtl/cpu_step_sequencer.sv
// cpu_step_sequencer: walks T1..Tlen per latched opcode, with hold, done and busy.
// Defining ILLEGAL_TRAP_EN turns zero-length opcodes into a sticky illegal trap instead of a NOP step.
module cpu_step_sequencer #(
  parameter int IW  = 12,
  parameter int OPW = 4,
  parameter int SW  = 4,
  parameter logic [(2**OPW)*SW-1:0] STEP_TABLE = 64'h0000_0000_0000_4321
) (
  input logic clk,
  input logic resetn,
  cpu_step_sequencer_if.slave bus
);
  logic [OPW-1:0] op, opcode_q, opcode_d;
  logic [SW-1:0]  len_op, len_q, len_d, step_q, step_d;
  logic           unused_instr;
  assign op           = bus.instruction[IW-1 -: OPW];
  assign len_op       = STEP_TABLE[op*SW +: SW];
  assign unused_instr = ^bus.instruction[IW-OPW-1:0];
`ifdef ILLEGAL_TRAP_EN
  logic ill_q, ill_d;
  always_ff @(posedge clk)
    if (!resetn) ill_q <= 1'b0;
    else ill_q <= ill_d;
  assign bus.illegal = ill_q;
`else
  assign bus.illegal = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!resetn) begin
      step_q   <= '0;
      len_q    <= '0;
      opcode_q <= '0;
    end else begin
      step_q   <= step_d;
      len_q    <= len_d;
      opcode_q <= opcode_d;
    end
  end
  always_comb begin
    step_d   = step_q;
    len_d    = len_q;
    opcode_d = opcode_q;
`ifdef ILLEGAL_TRAP_EN
    ill_d    = ill_q;
`endif
    if (!bus.hold) begin
      if (step_q != '0) step_d = (step_q == len_q) ? '0 : step_q + 1'b1;
`ifdef ILLEGAL_TRAP_EN
      else if (bus.illegal_clr) ill_d = 1'b0;
      else if (bus.w && !ill_q) begin
        opcode_d = op;
        len_d    = len_op;
        ill_d    = (len_op == '0);
        step_d   = (len_op == '0) ? '0 : SW'(1);
      end
`else
      else if (bus.w) begin
        opcode_d = op;
        len_d    = (len_op == '0) ? SW'(1) : len_op;
        step_d   = SW'(1);
      end
`endif
    end
  end
  assign bus.step     = step_q;
  assign bus.opcode_q = opcode_q;
  assign bus.busy     = (step_q != '0);
  assign bus.done     = (step_q != '0) && (step_q == len_q) && !bus.hold;
endmodule

// File: tb/tb_cpu_step_sequencer.sv
// tb_cpu_step_sequencer: two sequencers (default table and len(0)=15 table) driven in lockstep against a step-plan model.
module tb_cpu_step_sequencer;
  localparam logic [63:0] TBL_A = 64'h0000_0000_0000_4321;
  localparam logic [63:0] TBL_B = 64'h0000_0000_0000_432F;
  logic clk = 1'b0;
  logic resetn, w, hold, clr;
  logic [11:0] ins;
  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;
  int m_rem[2];
  int m_len[2];
  int m_op[2];
  int m_ill[2];
  always #5 clk = ~clk;
  cpu_step_sequencer_if a_if();
  cpu_step_sequencer_if b_if();
  assign a_if.w = w;
  assign a_if.hold = hold;
  assign a_if.instruction = ins;
  assign b_if.w = w;
  assign b_if.hold = hold;
  assign b_if.instruction = ins;
`ifdef ILLEGAL_TRAP_EN
  assign a_if.illegal_clr = clr;
  assign b_if.illegal_clr = clr;
`endif
  cpu_step_sequencer #(.STEP_TABLE(TBL_A)) u_a (.clk(clk), .resetn(resetn), .bus(a_if));
  cpu_step_sequencer #(.STEP_TABLE(TBL_B)) u_b (.clk(clk), .resetn(resetn), .bus(b_if));
  typedef struct {
    logic rn, wi, hi;
    logic [3:0] op;
    int step, opc;
    logic busy, done;
  } vec_t;
  vec_t tv[21];
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int len_of(input int d, input int op);
    logic [63:0] t;
    t = (d == 0) ? TBL_A : TBL_B;
    return int'((t >> (op * 4)) & 64'hF);
  endfunction
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rem[d] = -1; m_len[d] = 0; m_op[d] = 0; m_ill[d] = 0;
    end
  endtask
  // A sequence is "len steps still to go"; step shown is how far into that plan we are.
  task automatic model_edge();
    int l;
    if (!resetn) model_reset();
    else if (!hold) begin
      for (int d = 0; d < 2; d++) begin
        if (m_rem[d] > 0) m_rem[d]--;
        else if (m_rem[d] == 0) m_rem[d] = -1;
        else begin
          l = len_of(d, int'(ins[11:8]));
`ifdef ILLEGAL_TRAP_EN
          if (clr) m_ill[d] = 0;
          else if (w && m_ill[d] == 0) begin
            m_op[d] = int'(ins[11:8]);
            m_len[d] = l;
            if (l == 0) m_ill[d] = 1;
            else m_rem[d] = l - 1;
          end
`else
          if (w) begin
            m_op[d] = int'(ins[11:8]);
            m_len[d] = (l == 0) ? 1 : l;
            m_rem[d] = m_len[d] - 1;
          end
`endif
        end
      end
    end
  endtask
  task automatic model_check();
    int st[2];
    for (int d = 0; d < 2; d++) st[d] = (m_rem[d] < 0) ? 0 : m_len[d] - m_rem[d];
    cmp("a_step", 32'(a_if.step), st[0]);
    cmp("a_opcode", 32'(a_if.opcode_q), m_op[0]);
    cmp("a_busy", 32'(a_if.busy), 32'(st[0] != 0));
    cmp("a_done", 32'(a_if.done), 32'(m_rem[0] == 0 && !hold));
    cmp("a_illegal", 32'(a_if.illegal), m_ill[0]);
    cmp("b_step", 32'(b_if.step), st[1]);
    cmp("b_opcode", 32'(b_if.opcode_q), m_op[1]);
    cmp("b_busy", 32'(b_if.busy), 32'(st[1] != 0));
    cmp("b_done", 32'(b_if.done), 32'(m_rem[1] == 0 && !hold));
    cmp("b_illegal", 32'(b_if.illegal), m_ill[1]);
  endtask
  task automatic cyc(input logic r, input logic wi, input logic hi, input logic [3:0] op, input logic c);
    resetn = r; w = wi; hold = hi; clr = c;
    ins = {op, 8'($urandom)};
    @(negedge clk);
    if (chk_en) model_check();
    model_edge();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tv[0]  = '{1'b0, 1'b0, 1'b0, 4'd0, 0, 0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 4'd2, 0, 0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1, 2, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 4'd0, 2, 2, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 4'd0, 3, 2, 1'b1, 1'b1};
    tv[5]  = '{1'b1, 1'b1, 1'b0, 4'd3, 0, 2, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1, 3, 1'b1, 1'b0};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 4'd0, 2, 3, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 1'b1, 4'd1, 2, 3, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 4'd0, 2, 3, 1'b1, 1'b0};
    tv[10] = '{1'b1, 1'b0, 1'b0, 4'd0, 3, 3, 1'b1, 1'b0};
    tv[11] = '{1'b1, 1'b0, 1'b1, 4'd0, 4, 3, 1'b1, 1'b0};
    tv[12] = '{1'b1, 1'b0, 1'b0, 4'd0, 4, 3, 1'b1, 1'b1};
    tv[13] = '{1'b1, 1'b1, 1'b0, 4'd1, 0, 3, 1'b0, 1'b0};
    tv[14] = '{1'b1, 1'b1, 1'b0, 4'd3, 1, 1, 1'b1, 1'b0};
    tv[15] = '{1'b1, 1'b1, 1'b0, 4'd3, 2, 1, 1'b1, 1'b1};
    tv[16] = '{1'b1, 1'b0, 1'b0, 4'd0, 0, 1, 1'b0, 1'b0};
    tv[17] = '{1'b1, 1'b1, 1'b0, 4'd3, 0, 1, 1'b0, 1'b0};
    tv[18] = '{1'b1, 1'b0, 1'b0, 4'd0, 1, 3, 1'b1, 1'b0};
    tv[19] = '{1'b0, 1'b0, 1'b0, 4'd0, 2, 3, 1'b1, 1'b0};
    tv[20] = '{1'b1, 1'b0, 1'b0, 4'd0, 0, 0, 1'b0, 1'b0};
    model_reset();
    resetn = 1'b0; w = 1'b0; hold = 1'b0; clr = 1'b0; ins = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    for (int i = 0; i < 21; i++) begin
      resetn = tv[i].rn; w = tv[i].wi; hold = tv[i].hi; clr = 1'b0;
      ins = {tv[i].op, 8'($urandom)};
      @(negedge clk);
      cmp($sformatf("vec%0d_step", i), 32'(a_if.step), tv[i].step);
      cmp($sformatf("vec%0d_opcode", i), 32'(a_if.opcode_q), tv[i].opc);
      cmp($sformatf("vec%0d_busy", i), 32'(a_if.busy), 32'(tv[i].busy));
      cmp($sformatf("vec%0d_done", i), 32'(a_if.done), 32'(tv[i].done));
      model_check();
      model_edge();
      @(posedge clk);
      #1;
    end
`ifdef ILLEGAL_TRAP_EN
    cyc(1, 1, 0, 4'd5, 0);
    cmp("trap_set", 32'(a_if.illegal), 1);
    cmp("trap_step", 32'(a_if.step), 0);
    cyc(1, 1, 0, 4'd2, 0);
    cmp("trap_w_ignored", 32'(a_if.step), 0);
    cyc(1, 1, 0, 4'd2, 1);
    cmp("trap_clr", 32'(a_if.illegal), 0);
    cmp("trap_clr_wins", 32'(a_if.step), 0);
    cyc(1, 1, 0, 4'd2, 0);
    cmp("trap_restart", 32'(a_if.step), 1);
`else
    cyc(1, 1, 0, 4'd5, 0);
    cmp("nop_step", 32'(a_if.step), 1);
    cmp("nop_done", 32'(a_if.done), 1);
    cyc(1, 0, 0, 4'd0, 0);
    cmp("nop_end", 32'(a_if.step), 0);
`endif
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 4'd0, 0);
    cyc(1, 1, 0, 4'd0, 0);
    for (int i = 1; i <= 15; i++) begin
      cmp($sformatf("max_step%0d", i), 32'(b_if.step), i);
      cmp($sformatf("max_done%0d", i), 32'(b_if.done), 32'(i == 15));
      cyc(1, 0, 0, 4'd0, 0);
    end
    cmp("max_wrap", 32'(b_if.step), 0);
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 99) > 2), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
          4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
